// File: rtl/dbg_pkg.sv
// Shared definitions for the debug dump controller.
//   dump_state_t   : controller FSM state encoding
//   REGION_*       : debug region select codes carried on chk_addr[19:16]
//   WORD_BYTES     : bytes streamed per captured 32-bit debug word
//   LAST_BYTE_IDX  : byte index of the final byte of a word
//   addr_region()  : extracts the region select field from a debug address
package dbg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SEND   = 2'd2,
      DONE   = 2'd3
   } dump_state_t;

   localparam logic [3:0] REGION_CPU      = 4'd0;
   localparam logic [3:0] REGION_RF       = 4'd1;
   localparam logic [3:0] REGION_IMEM     = 4'd2;
   localparam logic [3:0] REGION_IRQ_IMEM = 4'd3;
   localparam logic [3:0] REGION_DMEM     = 4'd4;
   localparam logic [3:0] REGION_STACK    = 4'd5;

   localparam int         WORD_BYTES    = 4;
   localparam logic [1:0] LAST_BYTE_IDX = 2'(WORD_BYTES - 1);

   function automatic logic [3:0] addr_region(input logic [31:0] addr);
      return addr[19:16];
   endfunction

endpackage

// File: rtl/dbg_word_ser.sv
// Loads one 32-bit word and presents it as four bytes on a valid/ready channel.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture word and start presenting its first byte
//   word      : 32-bit word to serialize
//   stop      : on the current handshake, end the word early (abort)
//   tx_ready  : downstream accepts tx_data
//   tx_data   : current byte (MSB_FIRST selects [31:24] or [7:0] first)
//   tx_valid  : tx_data valid; only drops after a handshake
//   hs        : handshake this cycle
//   last_hs   : handshake of the final byte of the word
module dbg_word_ser
   import dbg_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] word,
   input  logic        stop,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        hs,
   output logic        last_hs
);

   logic [31:0] shreg;
   logic [1:0]  byte_idx;
   logic        valid_q;

   assign tx_valid = valid_q;
   assign tx_data  = MSB_FIRST ? shreg[31:24] : shreg[7:0];
   assign hs       = valid_q & tx_ready;
   assign last_hs  = hs & (byte_idx == LAST_BYTE_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= 32'h0;
         byte_idx <= 2'd0;
         valid_q  <= 1'b0;
      end else if (load) begin
         shreg    <= word;
         byte_idx <= 2'd0;
         valid_q  <= 1'b1;
      end else if (hs) begin
         // Shift the next byte into the output position.
         shreg    <= MSB_FIRST ? {shreg[23:0], 8'h00} : {8'h00, shreg[31:8]};
         byte_idx <= byte_idx + 2'd1;
         if (last_hs || stop) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/dbg_dump_ctrl.sv
// Debug-bus dump master: steps chk_addr through a word range, waits for the
// debug mux to settle, captures chk_data and streams each word as 4 bytes.
//   clk, rst           : clock, synchronous active-high reset
//   cmd_valid/ready    : dump command handshake (ready only in IDLE)
//   cmd_addr/cmd_count : first debug address, number of words
//   abort              : stop current dump (current byte still completes)
//   chk_addr/chk_data  : debug mux address out, data in
//   tx_data/valid/ready: byte stream toward UART TX
//   busy               : dump in progress (state != IDLE)
//   done/done_aborted  : one-cycle end-of-dump pulse and its abort qualifier
module dbg_dump_ctrl
   import dbg_pkg::*;
#(
   parameter int COUNT_W       = 16,
   parameter int SETTLE_CYCLES = 1,
   parameter bit MSB_FIRST     = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [31:0]        cmd_addr,
   input  logic [COUNT_W-1:0] cmd_count,
   input  logic               abort,
   output logic [31:0]        chk_addr,
   input  logic [31:0]        chk_data,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               busy,
   output logic               done,
   output logic               done_aborted
);

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

   dump_state_t        state, state_nxt;
   logic [3:0]         settle_cnt;
   logic [COUNT_W-1:0] rem;
   logic               abort_pend;
   logic               end_aborted;
   logic               ser_load;
   logic               ser_stop;
   logic               ser_hs;
   logic               ser_last;
   logic               last_word;

   assign last_word = (rem == COUNT_W'(1));
   // Capture happens on the final settle edge unless that same cycle aborts.
   assign ser_load  = (state == SETTLE) && !abort && (settle_cnt == 4'd1);
   assign ser_stop  = abort | abort_pend;

   dbg_word_ser #(
      .MSB_FIRST (MSB_FIRST)
   ) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (ser_load),
      .word     (chk_data),
      .stop     (ser_stop),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .hs       (ser_hs),
      .last_hs  (ser_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_nxt = (cmd_count == '0) ? DONE : SETTLE;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_nxt = DONE;
            end else if (settle_cnt == 4'd1) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            // An abort (pending or arriving now) ends the dump on the next
            // handshake, which also covers abort on the word's final byte.
            if (ser_hs && ser_stop) begin
               state_nxt = DONE;
            end else if (ser_last) begin
               state_nxt = last_word ? DONE : SETTLE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready    = (state == IDLE);
      busy         = (state != IDLE);
      done         = (state == DONE);
      done_aborted = (state == DONE) && end_aborted;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_addr    <= 32'h0;
         rem         <= '0;
         settle_cnt  <= 4'd0;
         abort_pend  <= 1'b0;
         end_aborted <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               abort_pend  <= 1'b0;
               end_aborted <= 1'b0;
               if (cmd_valid && (cmd_count != '0)) begin
                  chk_addr   <= cmd_addr;
                  rem        <= cmd_count;
                  settle_cnt <= SETTLE_INIT;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - 4'd1;
               if (abort) begin
                  end_aborted <= 1'b1;
               end
            end
            SEND: begin
               if (abort) begin
                  abort_pend <= 1'b1;
               end
               if (ser_last) begin
                  rem <= rem - COUNT_W'(1);
               end
               if (ser_hs && ser_stop) begin
                  end_aborted <= 1'b1;
               end else if (ser_last && !last_word) begin
                  // Modular increment: 0xFFFFFFFF wraps to 0.
                  chk_addr   <= chk_addr + 32'd1;
                  settle_cnt <= SETTLE_INIT;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_dump_ctrl.sv
module tb_dbg_dump_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- DUT A: SETTLE_CYCLES=1, MSB first ----------------
   logic        cmd_valid, cmd_ready, abort;
   logic [31:0] cmd_addr, chk_addr, chk_data, key;
   logic [15:0] cmd_count;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, busy, done, done_aborted;

   assign chk_data = chk_addr ^ key;

   dbg_dump_ctrl #(.COUNT_W(16), .SETTLE_CYCLES(1), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_count(cmd_count), .abort(abort),
      .chk_addr(chk_addr), .chk_data(chk_data), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
      .done_aborted(done_aborted));

   // ---------------- DUT B: SETTLE_CYCLES=3, LSB first, slow debug port ----
   logic        cmd_valid_b, cmd_ready_b, abort_b;
   logic [31:0] cmd_addr_b, chk_addr_b;
   logic [31:0] pipe_b = 32'h0;
   logic [31:0] chk_data_b = 32'h0;
   logic [15:0] cmd_count_b;
   logic [7:0]  tx_data_b;
   logic        tx_valid_b, tx_ready_b, busy_b, done_b, done_aborted_b;

   function automatic logic [31:0] mix(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Read data appears two edges after the address changes.
   always @(posedge clk) begin
      pipe_b     <= mix(chk_addr_b);
      chk_data_b <= pipe_b;
   end

   dbg_dump_ctrl #(.COUNT_W(16), .SETTLE_CYCLES(3), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
      .cmd_addr(cmd_addr_b), .cmd_count(cmd_count_b), .abort(abort_b),
      .chk_addr(chk_addr_b), .chk_data(chk_data_b), .tx_data(tx_data_b),
      .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .busy(busy_b), .done(done_b),
      .done_aborted(done_aborted_b));

   // ---------------- monitors (sample on falling edge) ----------------
   logic [7:0] q_a[$];
   int         rise_a[$];
   int         done_cnt_a = 0, done_cyc_a = 0, viol_a = 0;
   logic       last_ab_a = 1'b0, stall_a = 1'b0, prev_v_a = 1'b0;
   logic [7:0] stall_d_a = 8'h0;

   always @(negedge clk) begin
      if (rst) begin
         stall_a  <= 1'b0;
         prev_v_a <= 1'b0;
      end else begin
         if (stall_a && !(tx_valid && tx_data == stall_d_a)) viol_a <= viol_a + 1;
         stall_a   <= tx_valid && !tx_ready;
         stall_d_a <= tx_data;
         prev_v_a  <= tx_valid;
         if (tx_valid && !prev_v_a) rise_a.push_back(cyc);
         if (tx_valid && tx_ready) q_a.push_back(tx_data);
         if (done) begin
            done_cnt_a <= done_cnt_a + 1;
            last_ab_a  <= done_aborted;
            done_cyc_a <= cyc;
         end
      end
   end

   logic [7:0] q_b[$];
   int         rise_b[$];
   int         done_cnt_b = 0;
   logic       last_ab_b = 1'b0, prev_v_b = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_v_b <= 1'b0;
      end else begin
         prev_v_b <= tx_valid_b;
         if (tx_valid_b && !prev_v_b) rise_b.push_back(cyc);
         if (tx_valid_b && tx_ready_b) q_b.push_back(tx_data_b);
         if (done_b) begin
            done_cnt_b <= done_cnt_b + 1;
            last_ab_b  <= done_aborted_b;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] exp_q[$];

   task automatic build_exp(input logic [31:0] addr, input int n, input logic [31:0] k,
                            input bit msb, input bit slow_model);
      logic [31:0] a, w;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         a = addr + 32'(i);
         w = slow_model ? mix(a) : (a ^ k);
         for (int j = 0; j < 4; j++)
            exp_q.push_back(msb ? w[31 - 8*j -: 8] : w[8*j +: 8]);
      end
   endtask

   // ---------------- stimulus helper for DUT A ----------------
   // mode: 0 ready high, 1 random ready, 2 ready pattern 1,0,0,1
   // abort_sel: 0 none, 1 abort in SETTLE after word 0, 2 abort while byte 2 stalls
   task automatic dump_a(input logic [31:0] addr, input logic [15:0] n, input int mode,
                         input int abort_sel, output int acc, output bit ok_done);
      int base, d0, pat, stallc, sent;
      bit ab_done;
      base = q_a.size(); d0 = done_cnt_a; pat = 0; stallc = 0; ab_done = 0;
      tx_ready  = (mode == 0);
      cmd_addr  = addr;
      cmd_count = n;
      cmd_valid = 1'b1;
      for (int k = 0; k < 50 && !cmd_ready; k++) begin @(posedge clk); #1; end
      acc = cyc + 1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      ok_done = 0;
      for (int k = 0; k < 3000; k++) begin
         if (done_cnt_a != d0) begin ok_done = 1; break; end
         abort = 1'b0;
         sent  = q_a.size() - base;
         case (mode)
            0: tx_ready = 1'b1;
            1: tx_ready = 1'($urandom_range(0, 1));
            default: begin tx_ready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
         endcase
         if (abort_sel == 1 && !ab_done && sent == 4) begin
            abort = 1'b1; ab_done = 1;
         end
         if (abort_sel == 2) begin
            if (sent == 0 || ab_done) tx_ready = 1'b1;
            else begin
               tx_ready = 1'b0;
               stallc++;
               if (stallc == 3) begin abort = 1'b1; ab_done = 1; end
            end
         end
         @(posedge clk); #1;
      end
      abort = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 0; cmd_addr = 0; cmd_count = 0; abort = 0; tx_ready = 0; key = 0;
      cmd_valid_b = 0; cmd_addr_b = 0; cmd_count_b = 0; abort_b = 0; tx_ready_b = 0;
      repeat (3) @(posedge clk);
      #1;
      n_vec += 7;
      if (tx_valid !== 1'b0)     begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
      if (tx_data !== 8'h00)     begin n_err++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
      if (chk_addr !== 32'h0)    begin n_err++; $display("FAIL reset_chk_addr got %h want 0", chk_addr); end
      if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0)         begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      if (done_aborted !== 1'b0) begin n_err++; $display("FAIL reset_done_aborted got %b want 0", done_aborted); end
      if (cmd_ready !== 1'b1)    begin n_err++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int base, rbase, d0, acc; bit ok;
      key = 32'hA5A5A5A5;
      base = q_a.size(); rbase = rise_a.size(); d0 = done_cnt_a;
      dump_a(32'h00020000, 16'd2, 0, 0, acc, ok);
      repeat (3) begin @(posedge clk); #1; end
      build_exp(32'h00020000, 2, key, 1'b1, 1'b0);
      n_vec += 6;
      if (!ok) begin n_err++; $display("FAIL basic_done_seen got 0 want 1"); end
      if (done_cnt_a - d0 != 1) begin n_err++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt_a - d0); end
      if (last_ab_a !== 1'b0) begin n_err++; $display("FAIL basic_done_aborted got %b want 0", last_ab_a); end
      if (rise_a.size() <= rbase || rise_a[rbase] != acc + 1) begin
         n_err++; $display("FAIL basic_first_valid_latency got %0d want %0d",
                           (rise_a.size() > rbase) ? rise_a[rbase] - acc : -1, 1);
      end
      if (done_cyc_a != acc + 10) begin n_err++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc_a - acc, 10); end
      if (q_a.size() - base != 8) begin n_err++; $display("FAIL basic_byte_count got %0d want 8", q_a.size() - base); end
      else begin
         for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (q_a[base+i] !== exp_q[i]) begin n_err++; $display("FAIL basic_byte%0d got %h want %h", i, q_a[base+i], exp_q[i]); end
         end
      end
      n_vec++;
      if (chk_addr !== 32'h00020001) begin n_err++; $display("FAIL basic_addr_hold got %h want 00020001", chk_addr); end
   endtask

   task automatic test_backpressure();
      int base, v0, acc; bit ok; logic [31:0] a;
      a = $urandom; key = a ^ 32'h12345678;
      base = q_a.size(); v0 = viol_a;
      dump_a(a, 16'd1, 2, 0, acc, ok);
      build_exp(a, 1, key, 1'b1, 1'b0);
      n_vec += 3;
      if (!ok) begin n_err++; $display("FAIL bp_done_seen got 0 want 1"); end
      if (viol_a != v0) begin n_err++; $display("FAIL bp_hold_stable got %0d changes want 0", viol_a - v0); end
      if (q_a.size() - base != 4) begin n_err++; $display("FAIL bp_byte_count got %0d want 4", q_a.size() - base); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (q_a[base+i] !== exp_q[i]) begin n_err++; $display("FAIL bp_byte%0d got %h want %h", i, q_a[base+i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_zero_wrap();
      int base, rbase, acc; bit ok; logic [31:0] a0;
      a0 = chk_addr;
      base = q_a.size(); rbase = rise_a.size();
      dump_a($urandom, 16'd0, 0, 0, acc, ok);
      n_vec += 5;
      if (!ok) begin n_err++; $display("FAIL zero_done_seen got 0 want 1"); end
      if (done_cyc_a != acc) begin n_err++; $display("FAIL zero_done_cycle got %0d want 0", done_cyc_a - acc); end
      if (rise_a.size() != rbase || q_a.size() != base) begin n_err++; $display("FAIL zero_no_valid got %0d bytes want 0", q_a.size() - base); end
      if (last_ab_a !== 1'b0) begin n_err++; $display("FAIL zero_done_aborted got %b want 0", last_ab_a); end
      if (chk_addr !== a0) begin n_err++; $display("FAIL zero_addr_unchanged got %h want %h", chk_addr, a0); end

      key = $urandom;
      base = q_a.size();
      dump_a(32'hFFFFFFFF, 16'd2, 0, 0, acc, ok);
      build_exp(32'hFFFFFFFF, 2, key, 1'b1, 1'b0);
      n_vec += 3;
      if (!ok) begin n_err++; $display("FAIL wrap_done_seen got 0 want 1"); end
      if (chk_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got %h want 00000000", chk_addr); end
      if (q_a.size() - base != 8) begin n_err++; $display("FAIL wrap_byte_count got %0d want 8", q_a.size() - base); end
      else begin
         for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (q_a[base+i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_byte%0d got %h want %h", i, q_a[base+i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_abort();
      int base, acc; bit ok; logic [31:0] a;
      key = $urandom; a = $urandom;
      base = q_a.size();
      dump_a(a, 16'd3, 0, 1, acc, ok);
      build_exp(a, 1, key, 1'b1, 1'b0);
      n_vec += 3;
      if (!ok) begin n_err++; $display("FAIL abort_settle_done got 0 want 1"); end
      if (last_ab_a !== 1'b1) begin n_err++; $display("FAIL abort_settle_flag got %b want 1", last_ab_a); end
      if (q_a.size() - base != 4) begin n_err++; $display("FAIL abort_settle_bytes got %0d want 4", q_a.size() - base); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (q_a[base+i] !== exp_q[i]) begin n_err++; $display("FAIL abort_settle_byte%0d got %h want %h", i, q_a[base+i], exp_q[i]); end
         end
      end

      key = $urandom; a = $urandom;
      base = q_a.size();
      dump_a(a, 16'd2, 0, 2, acc, ok);
      build_exp(a, 1, key, 1'b1, 1'b0);
      n_vec += 3;
      if (!ok) begin n_err++; $display("FAIL abort_send_done got 0 want 1"); end
      if (last_ab_a !== 1'b1) begin n_err++; $display("FAIL abort_send_flag got %b want 1", last_ab_a); end
      if (q_a.size() - base != 2) begin n_err++; $display("FAIL abort_send_bytes got %0d want 2", q_a.size() - base); end
      else begin
         for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (q_a[base+i] !== exp_q[i]) begin n_err++; $display("FAIL abort_send_byte%0d got %h want %h", i, q_a[base+i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int base, d0; bit seen;
      base = q_a.size(); d0 = done_cnt_a; seen = 0;
      key = $urandom;
      tx_ready = 1'b0; cmd_addr = $urandom; cmd_count = 16'd5; cmd_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         if (tx_valid) begin seen = 1; break; end
      end
      n_vec++;
      if (!seen) begin n_err++; $display("FAIL rstmid_valid_seen got 0 want 1"); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_vec += 4;
      if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_tx_valid got %b want 0", tx_valid); end
      if (busy !== 1'b0)     begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
      if (chk_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_chk_addr got %h want 0", chk_addr); end
      if (done !== 1'b0)     begin n_err++; $display("FAIL rstmid_done got %b want 0", done); end
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_vec += 2;
      if (done_cnt_a != d0) begin n_err++; $display("FAIL rstmid_no_done got %0d pulses want 0", done_cnt_a - d0); end
      if (q_a.size() != base) begin n_err++; $display("FAIL rstmid_no_bytes got %0d want 0", q_a.size() - base); end
   endtask

   task automatic test_random();
      int base, v0, acc, nw, bad; bit ok; logic [31:0] a;
      for (int it = 0; it < 8; it++) begin
         key = $urandom; a = $urandom; nw = $urandom_range(1, 4);
         base = q_a.size(); v0 = viol_a;
         dump_a(a, 16'(nw), 1, 0, acc, ok);
         build_exp(a, nw, key, 1'b1, 1'b0);
         n_vec += 4;
         if (!ok) begin n_err++; $display("FAIL rand%0d_done got 0 want 1", it); end
         if (last_ab_a !== 1'b0) begin n_err++; $display("FAIL rand%0d_aborted got %b want 0", it, last_ab_a); end
         if (viol_a != v0) begin n_err++; $display("FAIL rand%0d_hold got %0d changes want 0", it, viol_a - v0); end
         if (q_a.size() - base != 4 * nw) begin
            n_err++; $display("FAIL rand%0d_bytes got %0d want %0d", it, q_a.size() - base, 4 * nw);
         end else begin
            bad = 0;
            for (int i = 0; i < 4 * nw; i++) if (q_a[base+i] !== exp_q[i]) bad++;
            n_vec++;
            if (bad != 0) begin n_err++; $display("FAIL rand%0d_data got %0d wrong bytes want 0", it, bad); end
         end
      end
   endtask

   task automatic test_settle3();
      int base, rbase, d0, acc; bit ok;
      base = q_b.size(); rbase = rise_b.size(); d0 = done_cnt_b;
      tx_ready_b = 1'b1; cmd_addr_b = 32'h00040010; cmd_count_b = 16'd4; cmd_valid_b = 1'b1;
      for (int k = 0; k < 50 && !cmd_ready_b; k++) begin @(posedge clk); #1; end
      acc = cyc + 1;
      @(posedge clk); #1;
      cmd_valid_b = 1'b0;
      ok = 0;
      for (int k = 0; k < 500; k++) begin
         if (done_cnt_b != d0) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      build_exp(32'h00040010, 4, 32'h0, 1'b0, 1'b1);
      n_vec += 4;
      if (!ok) begin n_err++; $display("FAIL s3_done got 0 want 1"); end
      if (last_ab_b !== 1'b0) begin n_err++; $display("FAIL s3_aborted got %b want 0", last_ab_b); end
      if (rise_b.size() <= rbase || rise_b[rbase] != acc + 3) begin
         n_err++; $display("FAIL s3_first_valid_latency got %0d want 3",
                           (rise_b.size() > rbase) ? rise_b[rbase] - acc : -1);
      end
      if (q_b.size() - base != 16) begin n_err++; $display("FAIL s3_bytes got %0d want 16", q_b.size() - base); end
      else begin
         for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (q_b[base+i] !== exp_q[i]) begin n_err++; $display("FAIL s3_byte%0d got %h want %h", i, q_b[base+i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_wrap();
      test_abort();
      test_reset_mid();
      test_random();
      test_settle3();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
